// File: rtl/aes_pkg.sv
// Shared AES constants and types: forward S-box, key-schedule round constants,
// round count and the key-expansion state encoding.
`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif

package aes_pkg;

    localparam int AES_BLOCK_SIZE = `AES_BLOCK_SIZE;
    localparam int AES_ROUNDS     = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } key_exp_state_t;

    // Round constant for the step that produces round key i (i = 1..10).
    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// One combinational AES-128 key-schedule step: derives round key i from round
// key i-1 and the round constant for i.
module aes_key_expand_step
    import aes_pkg::*;
(
    input  logic [127:0] Prev_key,
    input  logic [7:0]   Rcon,
    output logic [127:0] Next_key
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_rot, w_t;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign {w_w0, w_w1, w_w2, w_w3} = Prev_key;

    // RotWord then SubWord on the last word; the round constant lands in the top byte.
    assign w_rot = {w_w3[23:0], w_w3[31:24]};
    assign w_t   = sub_word(w_rot) ^ {Rcon, 24'h000000};

    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign Next_key = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: expands one key into eleven stored round keys
// over ten cycles, then serves any round key by index with one-cycle latency.
module aes_key_expansion
    import aes_pkg::*;
#(
    parameter int ROUNDS = AES_ROUNDS
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      Key_valid,
    input  logic [AES_BLOCK_SIZE-1:0] Key,
    output logic                      Key_ready,
    output logic                      Keys_ready,
    input  logic                      Round_req,
    input  logic [3:0]                Round_idx,
    output logic [AES_BLOCK_SIZE-1:0] Round_key,
    output logic                      Round_key_valid
);

    key_exp_state_t r_state;
    key_exp_state_t w_nextState;

    logic [3:0]                r_cnt;
    logic [AES_BLOCK_SIZE-1:0] r_work;
    logic [AES_BLOCK_SIZE-1:0] r_store [0:AES_ROUNDS];
    logic [AES_BLOCK_SIZE-1:0] r_roundKey;
    logic                      r_roundKeyValid;

    logic [AES_BLOCK_SIZE-1:0] w_nextKey;
    logic [7:0]                w_rcon;
    logic                      w_accept;
    logic                      w_readHit;
    logic                      w_lastStep;

    assign w_accept   = Key_valid && Key_ready;
    assign w_readHit  = Round_req && (r_state == READY) && (Round_idx <= 4'(ROUNDS));
    assign w_lastStep = (r_state == EXPAND) && (r_cnt == 4'(ROUNDS));
    assign w_rcon     = (r_cnt >= 4'd1 && r_cnt <= 4'(ROUNDS)) ? RCON[r_cnt] : 8'h00;

    aes_key_expand_step u_step (
        .Prev_key (r_work),
        .Rcon     (w_rcon),
        .Next_key (w_nextKey)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (w_accept)   w_nextState = EXPAND;
            EXPAND:  if (w_lastStep) w_nextState = READY;
            READY:   if (w_accept)   w_nextState = EXPAND;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        Key_ready  = (r_state != EXPAND);
        Keys_ready = (r_state == READY);
    end

    // Schedule storage is deliberately not reset; it is only readable in READY.
    always_ff @(posedge Clk) begin
        if (w_accept) begin
            r_store[0] <= Key;
            r_work     <= Key;
        end else if (r_state == EXPAND) begin
            r_store[r_cnt] <= w_nextKey;
            r_work         <= w_nextKey;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= 4'd1;
        end else if (w_lastStep) begin
            r_cnt <= 4'd0;
        end else if (r_state == EXPAND) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // A read in the same cycle as a rekey still sees the old schedule.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_roundKey      <= '0;
            r_roundKeyValid <= 1'b0;
        end else begin
            r_roundKeyValid <= w_readHit;
            if (w_readHit) begin
                r_roundKey <= r_store[Round_idx];
            end
        end
    end

    assign Round_key       = r_roundKey;
    assign Round_key_valid = r_roundKeyValid;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion: an arithmetic AES key-schedule
// model (S-box derived from GF(2^8) inverse) plus directed FIPS-197 vectors.
module tb_aes_key_expansion;

    typedef logic [0:10][127:0] schedT;

    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_A1_1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KEY_A1_X = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_B    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B_X  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         Key_valid;
    logic [127:0] Key;
    logic         Key_ready;
    logic         Keys_ready;
    logic         Round_req;
    logic [3:0]   Round_idx;
    logic [127:0] Round_key;
    logic         Round_key_valid;

    int nCompared   = 0;
    int nMismatched = 0;
    logic checkEn = 1'b0;

    aes_key_expansion dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .Key_valid       (Key_valid),
        .Key             (Key),
        .Key_ready       (Key_ready),
        .Keys_ready      (Keys_ready),
        .Round_req       (Round_req),
        .Round_idx       (Round_idx),
        .Round_key       (Round_key),
        .Round_key_valid (Round_key_valid)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from first principles: multiplicative inverse followed by the affine map.
    function automatic logic [7:0] sboxCalc(input logic [7:0] b);
        logic [7:0] inv = 8'h00;
        for (int c = 1; c < 256; c++) begin
            if (gmul(b, 8'(c)) == 8'h01) inv = 8'(c);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic schedT expandKey(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        schedT       s;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sboxCalc(t[31:24]), sboxCalc(t[23:16]), sboxCalc(t[15:8]), sboxCalc(t[7:0])}
                    ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Cycle-level model: a countdown of pending expansion cycles and a copy of the schedule.
    int           mCount;
    logic         mHave;
    logic         mRkv;
    logic [127:0] mRk;
    schedT        mSched;

    always @(posedge Clk) begin
        if (Rst) begin
            mCount <= 0;
            mHave  <= 1'b0;
            mRkv   <= 1'b0;
            mRk    <= '0;
        end else begin
            mRkv <= mHave && (mCount == 0) && Round_req && (Round_idx <= 4'd10);
            if (mHave && (mCount == 0) && Round_req && (Round_idx <= 4'd10)) mRk <= mSched[Round_idx];
            if (Key_valid && (mCount == 0)) begin
                mSched <= expandKey(Key);
                mCount <= 10;
                mHave  <= 1'b0;
            end else if (mCount > 0) begin
                mCount <= mCount - 1;
                if (mCount == 1) mHave <= 1'b1;
            end
        end
    end

    always @(negedge Clk) begin
        if (checkEn) begin
            checkOutput("model Key_ready", 128'(Key_ready), 128'(mCount == 0));
            checkOutput("model Keys_ready", 128'(Keys_ready), 128'(mHave && mCount == 0));
            checkOutput("model Round_key_valid", 128'(Round_key_valid), 128'(mRkv));
            checkOutput("model Round_key", Round_key, mRk);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic req, input logic [3:0] idx, input logic kv,
                                 input logic [127:0] k);
        Round_req = req;
        Round_idx = idx;
        Key_valid = kv;
        Key       = k;
        tick();
    endtask

    schedT refA1;
    schedT refB;
    int    n;

    initial begin
        Rst       = 1'b1;
        Key_valid = 1'b0;
        Key       = '0;
        Round_req = 1'b0;
        Round_idx = 4'd0;

        checkOutput("sbox(00)", 128'(sboxCalc(8'h00)), 128'h63);
        checkOutput("sbox(53)", 128'(sboxCalc(8'h53)), 128'hed);
        refA1 = expandKey(KEY_A1);
        refB  = expandKey(KEY_B);
        checkOutput("model A1 key0", refA1[0], KEY_A1);
        checkOutput("model A1 key1", refA1[1], KEY_A1_1);
        checkOutput("model A1 key10", refA1[10], KEY_A1_X);
        checkOutput("model B key10", refB[10], KEY_B_X);

        tick();
        checkEn = 1'b1;
        tick();
        checkOutput("reset Keys_ready", 128'(Keys_ready), 128'd0);
        checkOutput("reset Round_key_valid", 128'(Round_key_valid), 128'd0);
        checkOutput("reset Round_key", Round_key, 128'd0);
        Rst = 1'b0;
        tick();
        checkOutput("post-reset Key_ready", 128'(Key_ready), 128'd1);
        checkOutput("post-reset Keys_ready", 128'(Keys_ready), 128'd0);

        applyStimulus(1'b1, 4'd0, 1'b0, '0);
        checkOutput("idle read ignored", 128'(Round_key_valid), 128'd0);

        // Expansion of the FIPS-197 A.1 key, with a read held throughout EXPAND.
        applyStimulus(1'b0, 4'd0, 1'b1, KEY_A1);
        Key_valid = 1'b0;
        Round_req = 1'b1;
        Round_idx = 4'd3;
        n = 0;
        while (!Keys_ready && n < 30) begin
            tick();
            n++;
            checkOutput("read during EXPAND", 128'(Round_key_valid), 128'd0);
        end
        checkOutput("A1 expansion latency", 128'(n), 128'd10);

        applyStimulus(1'b1, 4'd0, 1'b0, '0);
        checkOutput("A1 idx0 valid", 128'(Round_key_valid), 128'd1);
        checkOutput("A1 idx0", Round_key, KEY_A1);
        applyStimulus(1'b1, 4'd1, 1'b0, '0);
        checkOutput("A1 idx1", Round_key, KEY_A1_1);
        applyStimulus(1'b1, 4'd10, 1'b0, '0);
        checkOutput("A1 idx10", Round_key, KEY_A1_X);
        applyStimulus(1'b1, 4'd11, 1'b0, '0);
        checkOutput("idx11 no pulse", 128'(Round_key_valid), 128'd0);
        checkOutput("idx11 key held", Round_key, KEY_A1_X);
        applyStimulus(1'b1, 4'd15, 1'b0, '0);
        checkOutput("idx15 no pulse", 128'(Round_key_valid), 128'd0);
        checkOutput("idx15 key held", Round_key, KEY_A1_X);

        for (int i = 10; i >= 0; i--) begin
            applyStimulus(1'b1, 4'(i), 1'b0, '0);
            checkOutput("sweep valid", 128'(Round_key_valid), 128'd1);
            checkOutput("sweep key", Round_key, refA1[i]);
        end

        // Rekey in READY with a same-cycle read, then a held key waiting for Key_ready.
        applyStimulus(1'b1, 4'd10, 1'b1, KEY_B);
        checkOutput("rekey same-cycle read", Round_key, KEY_A1_X);
        checkOutput("rekey same-cycle valid", 128'(Round_key_valid), 128'd1);
        Round_req = 1'b0;
        Key_valid = 1'b1;
        Key       = KEY_A1;
        n = 0;
        while (!Key_ready && n < 30) begin
            tick();
            n++;
        end
        checkOutput("B held-key wait", 128'(n), 128'd10);
        checkOutput("B Keys_ready", 128'(Keys_ready), 128'd1);
        applyStimulus(1'b1, 4'd10, 1'b1, KEY_A1);
        checkOutput("B idx10", Round_key, KEY_B_X);
        checkOutput("held key accepted", 128'(Keys_ready), 128'd0);
        checkOutput("held key busy", 128'(Key_ready), 128'd0);

        // Now in EXPAND cycle 1; reset lands during EXPAND cycle 5.
        Key_valid = 1'b0;
        Round_req = 1'b0;
        repeat (4) tick();
        Rst       = 1'b1;
        Round_req = 1'b1;
        Round_idx = 4'd2;
        tick();
        checkOutput("abort Key_ready", 128'(Key_ready), 128'd1);
        checkOutput("abort Keys_ready", 128'(Keys_ready), 128'd0);
        checkOutput("abort no pulse", 128'(Round_key_valid), 128'd0);
        Rst = 1'b0;
        applyStimulus(1'b0, 4'd0, 1'b1, KEY_B);
        Key_valid = 1'b0;
        n = 0;
        while (!Keys_ready && n < 30) begin
            tick();
            n++;
        end
        checkOutput("post-abort latency", 128'(n), 128'd10);
        applyStimulus(1'b1, 4'd10, 1'b0, '0);
        checkOutput("post-abort idx10", Round_key, KEY_B_X);
        applyStimulus(1'b1, 4'd7, 1'b0, '0);
        checkOutput("post-abort idx7", Round_key, refB[7]);
        applyStimulus(1'b0, 4'd0, 1'b0, '0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
